rtmq_serial_tx_ctrl: RTL and testbench

Transmit sequencer that drains the parallel word of an RTMQ output shift register onto a 3-wire serial link (`cs_n`, `sclk`, `sdo`), e.g. for a DAC or synthesizer. Writes into the output shift register assemble `dat_in`. A one-cycle trigger then latches the word and a frame length, and the block sends the selected bits MSB first with a programmable clock divider. It sits between the RTMQ peripheral bus registers and the chip pins, and reports `busy`/`done` back to the sequencer.

---
 rtl/rtmq_serial_tx_ctrl.sv | 159 +++++++++++++++
 tb/tb_rtmq_serial_tx_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtmq_serial_tx_ctrl.sv
// Serial transmit sequencer: drains a latched parallel word MSB-first onto cs_n/sclk/sdo
// (SPI mode 0) with a programmable half-period divider, reporting busy/done.
module rtmq_serial_tx_ctrl #(
  parameter int unsigned W_DAT = 192,
  parameter int unsigned W_LEN = 8,
  parameter int unsigned N_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_DAT-1:0] dat_in,
  input  logic [W_LEN-1:0] len,
  input  logic             trg,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             cs_n,
  output logic             sclk,
  output logic             sdo
);

  localparam int unsigned DivW = $clog2(N_DIV + 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold, StGap} state_e;

  state_e           state_q, state_d;
  logic [W_DAT-1:0] shreg_q, shreg_d;
  logic [W_LEN-1:0] bit_cnt_q, bit_cnt_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;

  logic [W_LEN-1:0] eff_len;
  logic [W_LEN-1:0] shamt;
  logic [W_DAT-1:0] load_word;
  logic             div_last;

  // Left-align the frame so the first bit to send sits at the MSB.
  assign eff_len   = (len > W_LEN'(W_DAT)) ? W_LEN'(W_DAT) : len;
  assign shamt     = W_LEN'(W_DAT) - eff_len;
  assign load_word = dat_in << shamt;
  assign div_last  = (div_q == DivW'(N_DIV - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;

    unique case (state_q)
      StIdle: begin
        if (trg) begin
          busy_d = 1'b1;
          div_d  = '0;
          if (eff_len != '0) begin
            state_d   = StShift;
            shreg_d   = load_word;
            bit_cnt_d = eff_len;
            cs_n_d    = 1'b0;
            sclk_d    = 1'b0;
            sdo_d     = load_word[W_DAT-1];
          end else begin
            state_d = StGap;
          end
        end
      end

      StShift: begin
        if (abort) begin
          state_d = StGap;
          div_d   = '0;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          sdo_d   = 1'b0;
        end else if (div_last) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // bit_cnt_q holds the bits still owed, including the one on the wire.
            if (bit_cnt_q == W_LEN'(1)) begin
              state_d   = StHold;
              bit_cnt_d = '0;
              sdo_d     = 1'b0;
            end else begin
              shreg_d   = shreg_q << 1;
              sdo_d     = shreg_q[W_DAT-2];
              bit_cnt_d = bit_cnt_q - W_LEN'(1);
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StHold: begin
        if (abort || div_last) begin
          state_d = StGap;
          div_d   = '0;
          cs_n_d  = 1'b1;
          sclk_d  = 1'b0;
          sdo_d   = 1'b0;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StGap: begin
        if (div_last) begin
          state_d = StIdle;
          div_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign cs_n = cs_n_q;
  assign sclk = sclk_q;
  assign sdo  = sdo_q;

endmodule

// File: tb/tb_rtmq_serial_tx_ctrl.sv
// Bench for rtmq_serial_tx_ctrl: directed scenarios plus random traffic, every cycle compared
// against a frame-timeline reference model.
module tb_rtmq_serial_tx_ctrl;

  localparam int W_DAT = 192;
  localparam int W_LEN = 8;
  localparam int N_DIV = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W_DAT-1:0] dat_in;
  logic [W_LEN-1:0] len;
  logic             trg;
  logic             abort;
  logic             busy, done, cs_n, sclk, sdo;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a frame is a timeline indexed by k = edges since the trigger edge.
  bit               m_active;
  bit               m_done;
  int               m_k;
  int               m_gap;
  int               m_len;
  logic [W_DAT-1:0] m_dat;

  // Monitors.
  int               cyc = 0;
  int               rises;
  logic [W_DAT-1:0] cap;
  logic             sclk_prev;
  int               t0;

  rtmq_serial_tx_ctrl #(
    .W_DAT(W_DAT),
    .W_LEN(W_LEN),
    .N_DIV(N_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dat_in(dat_in),
    .len   (len),
    .trg   (trg),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .sdo   (sdo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W_DAT-1:0] rand_word();
    logic [W_DAT-1:0] w;
    for (int i = 0; i < W_DAT / 32; i++) w[i*32+:32] = $urandom;
    return w;
  endfunction

  // Expected {busy, done, cs_n, sclk, sdo}.
  function automatic logic [4:0] exp_out();
    int t;
    t = 2 * N_DIV * m_len;
    if (!m_active) return {1'b0, m_done, 1'b1, 1'b0, 1'b0};
    if (m_k >= m_gap) return 5'b10100;
    if (m_k < t)
      return {1'b1, 1'b0, 1'b0, 1'((m_k % (2 * N_DIV)) >= N_DIV),
              m_dat[m_len - 1 - m_k / (2 * N_DIV)]};
    return 5'b10000;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_done    = 1'b0;
    m_k       = 0;
    m_gap     = 0;
    m_len     = 0;
    sclk_prev = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (m_active) begin
      if (abort && m_k < m_gap) m_gap = m_k + 1;
      m_k++;
      if (m_k == m_gap + N_DIV) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (trg) begin
      m_len    = (int'(len) > W_DAT) ? W_DAT : int'(len);
      m_dat    = dat_in;
      m_k      = 0;
      m_gap    = (m_len == 0) ? 0 : 2 * N_DIV * m_len + N_DIV;
      m_active = 1'b1;
    end
  endtask

  // Inputs are set at the falling edge; one clock later the pins are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_eq("pins", {27'd0, busy, done, cs_n, sclk, sdo}, {27'd0, exp_out()});
    if (sclk && !sclk_prev) begin
      rises++;
      cap = {cap[W_DAT-2:0], sdo};
    end
    sclk_prev = sclk;
  endtask

  task automatic start(input logic [W_DAT-1:0] d, input int l);
    dat_in = d;
    len    = W_LEN'(l);
    trg    = 1'b1;
    abort  = 1'b0;
    rises  = 0;
    cap    = '0;
    step();
    t0  = cyc;
    trg = 1'b0;
  endtask

  // Scrambles dat_in/len while waiting, so the in-flight frame must not depend on them.
  task automatic wait_done(input int budget, output int at);
    at    = -1;
    trg   = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < budget; i++) begin
      dat_in = rand_word();
      len    = W_LEN'($urandom_range(0, 255));
      step();
      if (done) begin
        at = cyc;
        return;
      end
    end
    check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic hit_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("reset_pins", {27'd0, busy, done, cs_n, sclk, sdo}, 32'b00100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int               at;
    int               ta;
    bit               seen;
    logic [W_DAT-1:0] d;

    rst_n  = 1'b1;
    trg    = 1'b0;
    abort  = 1'b0;
    dat_in = '0;
    len    = '0;
    rises  = 0;
    cap    = '0;
    #2;

    // Reset and idle.
    hit_reset();
    repeat (10) step();

    // Basic frame.
    start(W_DAT'(8'hA5), 8);
    wait_done(100, at);
    check_eq("basic_lat", at - t0, 36);
    check_eq("basic_rises", rises, 8);
    check_eq("basic_data", cap[31:0], 32'hA5);

    // Clamp to W_DAT.
    d = rand_word();
    start(d, 200);
    wait_done(1000, at);
    check_eq("clamp_lat", at - t0, 4 * N_DIV * 0 + 2 * N_DIV * W_DAT + 2 * N_DIV);
    check_eq("clamp_rises", rises, W_DAT);
    for (int i = 0; i < W_DAT / 32; i++) check_eq("clamp_word", cap[i*32+:32], d[i*32+:32]);

    // Empty frame.
    start(rand_word(), 0);
    wait_done(20, at);
    check_eq("empty_lat", at - t0, 2);
    check_eq("empty_rises", rises, 0);

    // Abort at the 5th sclk rise.
    start(rand_word(), 16);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = (rises == 5);
    end
    check_eq("abort_reach", 32'(seen), 32'd1);
    abort = 1'b1;
    ta    = cyc;
    step();
    abort = 1'b0;
    wait_done(20, at);
    check_eq("abort_lat", at - ta, N_DIV + 1);
    check_eq("abort_rises", rises, 5);

    // Triggers during a frame are ignored; a trigger on the done cycle starts the next frame.
    start(W_DAT'(8'h5A), 8);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      dat_in = rand_word();
      len    = W_LEN'($urandom_range(0, 255));
      trg    = 1'b1;
      step();
      seen = done;
    end
    check_eq("b2b_first_done", 32'(seen), 32'd1);
    check_eq("b2b_first_data", cap[31:0], 32'h5A);
    check_eq("b2b_first_rises", rises, 8);
    start(W_DAT'(8'h3C), 8);
    check_eq("b2b_immediate_cs", 32'(cs_n), 32'd0);
    wait_done(100, at);
    check_eq("b2b_second_data", cap[31:0], 32'h3C);
    check_eq("b2b_second_lat", at - t0, 36);

    // Reset mid-frame, then a clean frame.
    start(rand_word(), 16);
    repeat (10) step();
    hit_reset();
    repeat (5) step();
    start(W_DAT'(16'hC3E1), 16);
    wait_done(200, at);
    check_eq("post_rst_data", cap[31:0], 32'hC3E1);
    check_eq("post_rst_rises", rises, 16);

    // Random traffic against the model.
    rises = 0;
    cap   = '0;
    for (int i = 0; i < 1500; i++) begin
      trg    = ($urandom_range(0, 3) == 0);
      abort  = ($urandom_range(0, 15) == 0);
      len    = ($urandom_range(0, 7) == 0) ? W_LEN'($urandom_range(0, 255))
                                           : W_LEN'($urandom_range(0, 12));
      dat_in = rand_word();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
